// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - two-button mode controller for the seconds stopwatch
//
// Purpose:
//   Debounces buttons A (start/stop) and B (lap/reset), runs the IDLE/RUN/LAP/PAUSED
//   mode FSM, issues one-cycle start_stop / sw_reset commands, freezes the display
//   on a lap value and flags disagreement with the stopwatch's running flag.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   i_btn_a          raw button A (start/stop), active-high, asynchronous
//   i_btn_b          raw button B (lap/reset), active-high, asynchronous
//   i_seconds_in     live seconds count from the stopwatch (0-59)
//   i_running_in     running flag from the stopwatch
//   o_start_stop     one-cycle toggle command
//   o_sw_reset       one-cycle synchronous-reset command
//   o_disp_seconds   value to display (lap value while frozen)
//   o_lap_active     high while the display is frozen on a lap value
//   o_mode           0 IDLE, 1 RUN, 2 LAP, 3 PAUSED
//   o_sync_err       sticky expected/reported running mismatch

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_a,
    input  logic       i_btn_b,
    input  logic [6:0] i_seconds_in,
    input  logic       i_running_in,
    output logic       o_start_stop,
    output logic       o_sw_reset,
    output logic [6:0] o_disp_seconds,
    output logic       o_lap_active,
    output logic [1:0] o_mode,
    output logic       o_sync_err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LG_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } mode_t;

    // Button index 0 = A, 1 = B.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_lvl;
    logic [1:0]      r_lvl_d;
    logic [1:0]      r_ev;
    logic [DB_W-1:0] r_db_cnt [2];

    logic [LG_W-1:0] r_long_cnt;
    logic            r_long_done;

    mode_t           r_mode;
    logic            r_start_stop;
    logic            r_sw_reset;
    logic            r_pulse_d;
    logic [6:0]      r_lap_hold;
    logic [6:0]      r_disp;
    logic            r_lap_active;
    logic            r_sync_err;

    mode_t           w_next_mode;
    logic            w_ss_nxt;
    logic            w_rst_nxt;
    logic            w_lap_cap;
    logic [6:0]      w_lap_hold_nxt;
    logic            w_a_ev;
    logic            w_b_ev;
    logic            w_long_fire;
    logic            w_exp_run;
    logic            w_chk_en;

    assign w_a_ev      = r_ev[0];
    assign w_b_ev      = r_ev[1];
    // Fires once per hold, LONG_CYCLES edges after debounced B rose.
    assign w_long_fire = r_lvl[1] & ~r_long_done & (r_long_cnt == LG_LAST);

    // Synchronizers, debouncers and registered press events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_lvl       <= '0;
            r_lvl_d     <= '0;
            r_ev        <= '0;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
        end else begin
            r_sync1 <= {i_btn_b, i_btn_a};
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            r_ev    <= r_lvl & ~r_lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_lvl[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
            if (!r_lvl[1]) begin
                r_long_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (!r_long_done) begin
                if (r_long_cnt == LG_LAST) r_long_done <= 1'b1;
                else                       r_long_cnt  <= r_long_cnt + 1'b1;
            end
        end
    end

    // State register plus registered command/display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= IDLE;
            r_start_stop <= 1'b0;
            r_sw_reset   <= 1'b0;
            r_pulse_d    <= 1'b0;
            r_lap_hold   <= '0;
            r_disp       <= '0;
            r_lap_active <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_mode       <= w_next_mode;
            r_start_stop <= w_ss_nxt;
            r_sw_reset   <= w_rst_nxt;
            r_pulse_d    <= r_start_stop | r_sw_reset;
            r_lap_hold   <= w_lap_hold_nxt;
            r_lap_active <= (w_next_mode == LAP);
            // Display switches in the same cycle as lap_active.
            r_disp       <= (w_next_mode == LAP) ? w_lap_hold_nxt : i_seconds_in;
            if (w_rst_nxt)
                r_sync_err <= 1'b0;
            else if (w_chk_en && (i_running_in != w_exp_run))
                r_sync_err <= 1'b1;
        end
    end

    // Next-state logic; a long-press fire outranks A, and A outranks B.
    always_comb begin
        w_next_mode = r_mode;
        if (w_long_fire) begin
            w_next_mode = IDLE;
        end else if (w_a_ev) begin
            case (r_mode)
                IDLE:    w_next_mode = RUN;
                RUN:     w_next_mode = PAUSED;
                LAP:     w_next_mode = PAUSED;
                default: w_next_mode = RUN;
            endcase
        end else if (w_b_ev) begin
            case (r_mode)
                RUN:     w_next_mode = LAP;
                LAP:     w_next_mode = RUN;
                PAUSED:  w_next_mode = IDLE;
                default: w_next_mode = r_mode;
            endcase
        end
    end

    // Output decisions, registered in the state-register process.
    always_comb begin
        w_ss_nxt       = 1'b0;
        w_rst_nxt      = 1'b0;
        w_lap_cap      = 1'b0;
        w_lap_hold_nxt = r_lap_hold;
        if (w_long_fire) begin
            w_rst_nxt = 1'b1;
        end else if (w_a_ev) begin
            w_ss_nxt = 1'b1;
        end else if (w_b_ev) begin
            w_rst_nxt = (r_mode == PAUSED);
            w_lap_cap = (r_mode == RUN);
        end
        if (w_long_fire)    w_lap_hold_nxt = '0;
        else if (w_lap_cap) w_lap_hold_nxt = i_seconds_in;
    end

    // The stopwatch reacts one edge after a command, so skip the pulse cycle and the next.
    assign w_exp_run = (r_mode == RUN) || (r_mode == LAP);
    assign w_chk_en  = ~(r_start_stop | r_sw_reset | r_pulse_d);

    assign o_start_stop   = r_start_stop;
    assign o_sw_reset     = r_sw_reset;
    assign o_disp_seconds = r_disp;
    assign o_lap_active   = r_lap_active;
    assign o_mode         = r_mode;
    assign o_sync_err     = r_sync_err;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int K_SS  = 1;
    localparam int K_RST = 2;

    logic       clk;
    logic       rst_n;
    logic       btn_a;
    logic       btn_b;
    logic [6:0] seconds;
    logic       running;
    logic       start_stop;
    logic       sw_reset;
    logic [6:0] disp_seconds;
    logic       lap_active;
    logic [1:0] mode;
    logic       sync_err;

    logic       m_run;
    logic       force_en;

    typedef struct {
        int kind;
        int cyc;
        int mode;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_a       (btn_a),
        .i_btn_b       (btn_b),
        .i_seconds_in  (seconds),
        .i_running_in  (running),
        .o_start_stop  (start_stop),
        .o_sw_reset    (sw_reset),
        .o_disp_seconds(disp_seconds),
        .o_lap_active  (lap_active),
        .o_mode        (mode),
        .o_sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stopwatch model: toggles on start_stop, clears on sw_reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        m_run <= 1'b0;
        else if (sw_reset) m_run <= 1'b0;
        else if (start_stop) m_run <= ~m_run;
    end

    assign running = force_en ? 1'b0 : m_run;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor: every command pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (start_stop || sw_reset)) begin
            check("pulse_excl", int'(start_stop & sw_reset), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", int'({sw_reset, start_stop}), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_kind", int'({sw_reset, start_stop}), e.kind);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_mode", int'(mode), e.mode);
            end
        end
    end

    // Drive button for 'hold' cycles, expect an optional pulse 'dly' cycles after drive.
    task automatic press(input int which, input int hold, input int kind, input int dly,
                         input int exp_mode);
        if (kind != 0) sb_q.push_back('{kind, cyc + dly, exp_mode});
        if (which == 0) btn_a = 1'b1; else btn_b = 1'b1;
        repeat (hold) @(negedge clk);
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (12) @(negedge clk);
        check("pulse_seen", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_a    = 1'b0;
        btn_b    = 1'b0;
        seconds  = 7'd0;
        force_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", int'(mode), 0);
        check("rst_ss", int'(start_stop), 0);
        check("rst_swr", int'(sw_reset), 0);
        check("rst_disp", int'(disp_seconds), 0);
        check("rst_lap", int'(lap_active), 0);
        check("rst_err", int'(sync_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Glitchy A never debounces.
        for (int i = 0; i < 4; i++) begin
            btn_a = 1'b1;
            repeat (3) @(negedge clk);
            btn_a = 1'b0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_mode", int'(mode), 0);

        // Clean A from IDLE: pulse 7 cycles after first sampling edge.
        press(0, 10, K_SS, DB + 4, 1);
        check("a_run_mode", int'(mode), 1);
        check("a_run_err", int'(sync_err), 0);

        // Lap freeze and release.
        seconds = 7'd17;
        repeat (2) @(negedge clk);
        press(1, 10, 0, 0, 0);
        check("lap_mode", int'(mode), 2);
        check("lap_active", int'(lap_active), 1);
        for (int s = 18; s <= 20; s++) begin
            seconds = 7'(s);
            repeat (2) @(negedge clk);
            check("lap_frozen", int'(disp_seconds), 17);
        end
        press(1, 10, 0, 0, 0);
        check("unlap_mode", int'(mode), 1);
        check("unlap_active", int'(lap_active), 0);
        check("unlap_disp", int'(disp_seconds), 20);
        seconds = 7'd59;
        @(negedge clk);
        seconds = 7'd0;
        @(negedge clk);
        check("wrap_disp", int'(disp_seconds), 0);

        // Pause, then B resets.
        press(0, 10, K_SS, DB + 4, 3);
        check("pause_mode", int'(mode), 3);
        press(1, 10, K_RST, DB + 4, 0);
        check("reset_mode", int'(mode), 0);
        check("reset_err", int'(sync_err), 0);

        // Long press from RUN: LAP first, then one sw_reset LG cycles after debounced-high.
        press(0, 10, K_SS, DB + 4, 1);
        sb_q.push_back('{K_RST, cyc + DB + 2 + LG, 0});
        btn_b = 1'b1;
        repeat (12) @(negedge clk);
        check("long_lap_mode", int'(mode), 2);
        check("long_lap_active", int'(lap_active), 1);
        repeat (18) @(negedge clk);
        btn_b = 1'b0;
        repeat (12) @(negedge clk);
        check("long_seen", sb_q.size(), 0);
        sb_q.delete();
        check("long_mode", int'(mode), 0);
        check("long_lap_clr", int'(lap_active), 0);
        check("long_err", int'(sync_err), 0);

        // Running mismatch sets sticky sync_err; sw_reset clears it.
        press(0, 10, K_SS, DB + 4, 1);
        check("pre_err", int'(sync_err), 0);
        force_en = 1'b1;
        repeat (3) @(negedge clk);
        force_en = 1'b0;
        @(negedge clk);
        check("err_set", int'(sync_err), 1);
        repeat (5) @(negedge clk);
        check("err_sticky", int'(sync_err), 1);
        press(0, 10, K_SS, DB + 4, 3);
        check("err_hold_pause", int'(sync_err), 1);
        press(1, 10, K_RST, DB + 4, 0);
        check("err_cleared", int'(sync_err), 0);
        check("final_mode", int'(mode), 0);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Two-button user-interface controller that sequences the seconds stopwatch datapath.
- Debounces raw buttons A (start/stop) and B (lap/reset) and runs a mode FSM.
- Issues one-cycle start_stop and reset command pulses to the stopwatch.
- Provides a lap-freeze display path and a sticky consistency check against the stopwatch's running flag.

Parameters:
- DEBOUNCE_CYCLES, 500_000: consecutive stable cycles before a debounced button level changes; minimum 2.
- LONG_CYCLES, 100_000_000: cycles button B must stay debounced-high to force a long-press reset; must exceed DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_a  in  1  raw asynchronous button A, active-high
- btn_b  in  1  raw asynchronous button B, active-high
- seconds_in  in  7  live seconds count from stopwatch (0-59)
- running_in  in  1  running flag from stopwatch
- start_stop  out  1  one-cycle toggle command to stopwatch
- sw_reset  out  1  one-cycle synchronous-reset command to stopwatch
- disp_seconds  out  7  value to display
- lap_active  out  1  high while display is frozen on a lap value
- mode  out  2  FSM state: 0 IDLE, 1 RUN, 2 LAP, 3 PAUSED
- sync_err  out  1  sticky mismatch between expected and reported running state

Behaviour:
- Reset: the only reset is rst_n, asynchronous, active-low, on clock clk. While rst_n is low all registers clear, all outputs are 0, and mode=IDLE.
- Input path: each button passes through a 2-flop synchronizer.
  - The debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle of agreement clears the debounce counter.
- Press event: one-cycle, on a debounced 0->1 transition. Release produces no event.
- Latency: an input held stably high produces its command pulse exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples it high. Commands are registered, and each pulse is exactly 1 cycle wide.
- FSM transitions (A = A press event, B = B press event):
  - IDLE: A -> pulse start_stop, go RUN. B -> ignored.
  - RUN: A -> pulse start_stop, go PAUSED. B -> capture seconds_in into lap_hold, go LAP.
  - LAP: A -> pulse start_stop, go PAUSED (lap released). B -> go RUN (lap released, no pulse).
  - PAUSED: A -> pulse start_stop, go RUN. B -> pulse sw_reset, go IDLE.
- Long press:
  - A counter runs while debounced B is high and saturates once it fires.
  - On reaching LONG_CYCLES it pulses sw_reset once per hold from any state, forcing IDLE and clearing lap_hold.
  - The counter clears when debounced B goes low.
  - A long press therefore follows whatever the initial B press already did (e.g. RUN -> LAP -> IDLE).
- Simultaneous A and B events in one cycle: A wins and the B event is dropped.
  - A long-press fire in the same cycle as an A event wins over A: sw_reset only, go IDLE, no start_stop.
- start_stop and sw_reset are never high in the same cycle.
- Display:
  - disp_seconds is registered with 1-cycle latency.
  - It shows lap_hold when mode=LAP, otherwise seconds_in.
  - lap_active = (mode==LAP), registered with mode.
- Consistency check:
  - Expected running = mode in {RUN, LAP}.
  - The comparison is suppressed during the cycle a command pulse is high and the following cycle.
  - Otherwise, running_in != expected sets sync_err. sync_err stays set until an sw_reset pulse is issued; it clears in the same cycle as that pulse.
- seconds_in wrap 59->0 passes through unmodified; no arithmetic is done on it.
- Reset mid-press: debounce, synchronizer and long-press state all clear. A button still held after rst_n release must be re-debounced (low->high) before it produces an event.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, bench stopwatch model):
- Press A clean for 10 cycles from IDLE -> start_stop high for exactly 1 cycle, 7 cycles after first high sample; mode=1; running_in follows, sync_err stays 0.
- Glitchy A: 3-cycle highs separated by 1-cycle lows -> no start_stop ever, mode stays 0.
- RUN with seconds_in=17, press B -> mode=2, lap_active=1, disp_seconds stays 17 while seconds_in advances to 20; press B again -> disp_seconds tracks live 20, mode=1.
- RUN, press A -> mode=3; press B -> sw_reset single pulse, mode=0, no start_stop.
- RUN, hold B 30 cycles -> LAP after B press, then exactly one sw_reset 20 cycles after debounced-high; mode=0; lap_active=0.
- RUN, bench forces running_in=0 for 3 cycles with no pulse -> sync_err=1 and stays; a later sw_reset clears it.
